// File: rtl/csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : csr_trap_ctrl
// Purpose  : Machine-mode trap / interrupt sequencer. On ecall, ebreak,
//            a pending enabled interrupt or mret it stalls the pipeline,
//            updates the CSR file through its secondary write port (one
//            CSR per cycle) and then pulses a redirect to the fetch stage.
//
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            ecall_i/ebreak_i    - decode: synchronous trap instructions
//            mret_i              - decode: return from trap
//            inst_addr_i         - PC of the instruction in decode
//            jump_flag_i/addr_i  - ex: taken branch/jump and its target
//            int_flag_i          - pending interrupts [0]=timer [1]=external
//            global_int_en_i     - mstatus.MIE
//            ex_csr_we_i         - ex stage owns the CSR write port this cycle
//            csr_mtvec_i/mepc_i/mstatus_i - current CSR values
//            csr_we_o/waddr_o/wdata_o     - secondary CSR write port
//            hold_flag_o         - pipeline stall
//            int_assert_o/int_addr_o      - one-cycle redirect and target
//
// Options  : CSR_TRAP_VECTORED_EN - when defined and mtvec[1:0]==2'b01,
//            asynchronous traps vector to base + 4*cause[30:0].
//
// Revision : 1.0 - initial release
// ============================================================================
module csr_trap_ctrl #(
    parameter int ADDR_W = 32,
    parameter int CSR_AW = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ecall_i,
    input  logic              ebreak_i,
    input  logic              mret_i,
    input  logic [ADDR_W-1:0] inst_addr_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic [1:0]        int_flag_i,
    input  logic              global_int_en_i,
    input  logic              ex_csr_we_i,
    input  logic [ADDR_W-1:0] csr_mtvec_i,
    input  logic [ADDR_W-1:0] csr_mepc_i,
    input  logic [ADDR_W-1:0] csr_mstatus_i,
    output logic              csr_we_o,
    output logic [CSR_AW-1:0] csr_waddr_o,
    output logic [ADDR_W-1:0] csr_wdata_o,
    output logic              hold_flag_o,
    output logic              int_assert_o,
    output logic [ADDR_W-1:0] int_addr_o
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [CSR_AW-1:0] c_addr_mstatus = CSR_AW'(12'h300);
    localparam logic [CSR_AW-1:0] c_addr_mepc    = CSR_AW'(12'h341);
    localparam logic [CSR_AW-1:0] c_addr_mcause  = CSR_AW'(12'h342);

    localparam logic [ADDR_W-1:0] c_cause_ecall  = ADDR_W'(11);
    localparam logic [ADDR_W-1:0] c_cause_ebreak = ADDR_W'(3);
    // Interrupt causes carry the interrupt flag in the MSB.
    localparam logic [ADDR_W-1:0] c_cause_timer  = {1'b1, (ADDR_W-1)'(7)};
    localparam logic [ADDR_W-1:0] c_cause_ext    = {1'b1, (ADDR_W-1)'(11)};

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_W_MEPC    = 3'd1,
        S_W_MCAUSE  = 3'd2,
        S_W_MSTATUS = 3'd3,
        S_T_JUMP    = 3'd4,
        S_R_MSTATUS = 3'd5,
        S_R_JUMP    = 3'd6
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cause_q, cause_d;
    logic [ADDR_W-1:0] epc_q,   epc_d;

    // ------------------------------------------------------------------------
    // Event detection. Gated by rst_n so that every output, including the
    // combinational hold, reads zero while reset is asserted.
    // ------------------------------------------------------------------------
    logic w_sync_ev;
    logic w_mret_ev;
    logic w_async_ev;

    assign w_sync_ev  = rst_n & (ecall_i | ebreak_i);
    assign w_mret_ev  = rst_n & mret_i;
    assign w_async_ev = rst_n & global_int_en_i & (|int_flag_i);

    // ------------------------------------------------------------------------
    // mstatus rewrites
    //   trap entry : MPIE <= MIE, MIE <= 0
    //   mret       : MIE  <= MPIE, MPIE <= 1
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_mstatus_trap;
    logic [ADDR_W-1:0] w_mstatus_mret;

    always_comb begin
        w_mstatus_trap    = csr_mstatus_i;
        w_mstatus_trap[7] = csr_mstatus_i[3];
        w_mstatus_trap[3] = 1'b0;
    end

    always_comb begin
        w_mstatus_mret    = csr_mstatus_i;
        w_mstatus_mret[3] = csr_mstatus_i[7];
        w_mstatus_mret[7] = 1'b1;
    end

    // ------------------------------------------------------------------------
    // Trap vector target. mtvec[1:0] is the mode field and never part of
    // the address.
    // ------------------------------------------------------------------------
    logic [ADDR_W-1:0] w_mtvec_base;
    logic [ADDR_W-1:0] w_trap_target;

    assign w_mtvec_base = {csr_mtvec_i[ADDR_W-1:2], 2'b00};

`ifdef CSR_TRAP_VECTORED_EN
    // Vectored mode applies to interrupts only (cause MSB set); exceptions
    // always enter at the base. The shifted cause wraps within ADDR_W.
    logic w_vectored;

    assign w_vectored    = (csr_mtvec_i[1:0] == 2'b01) && cause_q[ADDR_W-1];
    assign w_trap_target = w_vectored ? (w_mtvec_base + {cause_q[ADDR_W-3:0], 2'b00})
                                      : w_mtvec_base;
`else
    logic w_unused_mtvec_mode;

    assign w_unused_mtvec_mode = &{1'b0, csr_mtvec_i[1:0]};
    assign w_trap_target       = w_mtvec_base;
`endif

    // ------------------------------------------------------------------------
    // State and capture registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            state_q <= state_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cause_d      = cause_q;
        epc_d        = epc_q;
        csr_we_o     = 1'b0;
        csr_waddr_o  = '0;
        csr_wdata_o  = '0;
        int_assert_o = 1'b0;
        int_addr_o   = '0;
        hold_flag_o  = (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                // Priority: synchronous exception > mret > interrupt.
                // Events seen in any other state are dropped, not queued.
                if (w_sync_ev) begin
                    hold_flag_o = 1'b1;
                    cause_d     = ecall_i ? c_cause_ecall : c_cause_ebreak;
                    epc_d       = inst_addr_i;
                    state_d     = S_W_MEPC;
                end else if (w_mret_ev) begin
                    hold_flag_o = 1'b1;
                    state_d     = S_R_MSTATUS;
                end else if (w_async_ev) begin
                    hold_flag_o = 1'b1;
                    cause_d     = int_flag_i[1] ? c_cause_ext : c_cause_timer;
                    // A taken jump in ex means the instruction in decode is
                    // on the wrong path; resume at the jump target instead.
                    epc_d       = jump_flag_i ? jump_addr_i : inst_addr_i;
                    state_d     = S_W_MEPC;
                end
            end

            // In every write state the ex port wins the CSR file, so the
            // write is held and repeated until ex releases it.
            S_W_MEPC: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = c_addr_mepc;
                csr_wdata_o = epc_q;
                if (!ex_csr_we_i) begin
                    state_d = S_W_MCAUSE;
                end
            end

            S_W_MCAUSE: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = c_addr_mcause;
                csr_wdata_o = cause_q;
                if (!ex_csr_we_i) begin
                    state_d = S_W_MSTATUS;
                end
            end

            S_W_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = c_addr_mstatus;
                csr_wdata_o = w_mstatus_trap;
                if (!ex_csr_we_i) begin
                    state_d = S_T_JUMP;
                end
            end

            S_T_JUMP: begin
                int_assert_o = 1'b1;
                int_addr_o   = w_trap_target;
                state_d      = S_IDLE;
            end

            S_R_MSTATUS: begin
                csr_we_o    = 1'b1;
                csr_waddr_o = c_addr_mstatus;
                csr_wdata_o = w_mstatus_mret;
                if (!ex_csr_we_i) begin
                    state_d = S_R_JUMP;
                end
            end

            S_R_JUMP: begin
                int_assert_o = 1'b1;
                int_addr_o   = csr_mepc_i;
                state_d      = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_csr_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_csr_trap_ctrl
// Purpose  : Self-checking bench for csr_trap_ctrl. A reference model keeps
//            a queue of pending sequencer actions (write mepc, write mcause,
//            write mstatus, jump, ...) and predicts every output each cycle.
//            Directed scenarios are followed by randomized traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_csr_trap_ctrl;

    localparam int ADDR_W = 32;
    localparam int CSR_AW = 12;

    // Model action codes
    localparam int c_a_w_mepc    = 0;
    localparam int c_a_w_mcause  = 1;
    localparam int c_a_w_mstatus = 2;
    localparam int c_a_t_jump    = 3;
    localparam int c_a_r_mstatus = 4;
    localparam int c_a_r_jump    = 5;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ecall_i, ebreak_i, mret_i;
    logic [ADDR_W-1:0] inst_addr_i;
    logic              jump_flag_i;
    logic [ADDR_W-1:0] jump_addr_i;
    logic [1:0]        int_flag_i;
    logic              global_int_en_i;
    logic              ex_csr_we_i;
    logic [ADDR_W-1:0] csr_mtvec_i, csr_mepc_i, csr_mstatus_i;
    logic              csr_we_o;
    logic [CSR_AW-1:0] csr_waddr_o;
    logic [ADDR_W-1:0] csr_wdata_o;
    logic              hold_flag_o;
    logic              int_assert_o;
    logic [ADDR_W-1:0] int_addr_o;

    always #5 clk = ~clk;

    csr_trap_ctrl #(
        .ADDR_W (ADDR_W),
        .CSR_AW (CSR_AW)
    ) u_dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ecall_i         (ecall_i),
        .ebreak_i        (ebreak_i),
        .mret_i          (mret_i),
        .inst_addr_i     (inst_addr_i),
        .jump_flag_i     (jump_flag_i),
        .jump_addr_i     (jump_addr_i),
        .int_flag_i      (int_flag_i),
        .global_int_en_i (global_int_en_i),
        .ex_csr_we_i     (ex_csr_we_i),
        .csr_mtvec_i     (csr_mtvec_i),
        .csr_mepc_i      (csr_mepc_i),
        .csr_mstatus_i   (csr_mstatus_i),
        .csr_we_o        (csr_we_o),
        .csr_waddr_o     (csr_waddr_o),
        .csr_wdata_o     (csr_wdata_o),
        .hold_flag_o     (hold_flag_o),
        .int_assert_o    (int_assert_o),
        .int_addr_o      (int_addr_o)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------------
    int          act_q[$];
    logic [31:0] m_cause = '0;
    logic [31:0] m_epc   = '0;

    function automatic logic [31:0] mstatus_on_trap(input logic [31:0] s);
        logic [31:0] r;
        r    = s;
        r[7] = s[3];
        r[3] = 1'b0;
        return r;
    endfunction

    function automatic logic [31:0] mstatus_on_mret(input logic [31:0] s);
        logic [31:0] r;
        r    = s;
        r[3] = s[7];
        r[7] = 1'b1;
        return r;
    endfunction

    function automatic logic [31:0] trap_target(input logic [31:0] cause, input logic [31:0] mtvec);
        logic [31:0] base;
        base = mtvec & 32'hFFFF_FFFC;
`ifdef CSR_TRAP_VECTORED_EN
        if (mtvec[1:0] == 2'b01 && cause[31])
            return base + (cause & 32'h7FFF_FFFF) * 4;
`endif
        return base;
    endfunction

    function automatic bit is_write(input int a);
        return (a == c_a_w_mepc) || (a == c_a_w_mcause) ||
               (a == c_a_w_mstatus) || (a == c_a_r_mstatus);
    endfunction

    task automatic check_model();
        logic        e_hold, e_we, e_ia;
        logic [31:0] e_waddr, e_wdata, e_iaddr;
        e_hold = 0; e_we = 0; e_ia = 0;
        e_waddr = 0; e_wdata = 0; e_iaddr = 0;
        if (rst_n) begin
            if (act_q.size() == 0) begin
                e_hold = ecall_i | ebreak_i | mret_i |
                         (global_int_en_i && int_flag_i != 2'b00);
            end else begin
                e_hold = 1;
                case (act_q[0])
                    c_a_w_mepc:    begin e_we = 1; e_waddr = 32'h341; e_wdata = m_epc; end
                    c_a_w_mcause:  begin e_we = 1; e_waddr = 32'h342; e_wdata = m_cause; end
                    c_a_w_mstatus: begin e_we = 1; e_waddr = 32'h300; e_wdata = mstatus_on_trap(csr_mstatus_i); end
                    c_a_t_jump:    begin e_ia = 1; e_iaddr = trap_target(m_cause, csr_mtvec_i); end
                    c_a_r_mstatus: begin e_we = 1; e_waddr = 32'h300; e_wdata = mstatus_on_mret(csr_mstatus_i); end
                    default:       begin e_ia = 1; e_iaddr = csr_mepc_i; end
                endcase
            end
        end
        chk("hold",   32'(hold_flag_o),  32'(e_hold));
        chk("we",     32'(csr_we_o),     32'(e_we));
        chk("waddr",  32'(csr_waddr_o),  e_waddr);
        chk("wdata",  csr_wdata_o,       e_wdata);
        chk("assert", 32'(int_assert_o), 32'(e_ia));
        chk("iaddr",  int_addr_o,        e_iaddr);
    endtask

    task automatic advance_model();
        if (!rst_n) begin
            act_q.delete();
        end else if (act_q.size() == 0) begin
            if (ecall_i || ebreak_i) begin
                m_cause = ecall_i ? 32'd11 : 32'd3;
                m_epc   = inst_addr_i;
                act_q   = '{c_a_w_mepc, c_a_w_mcause, c_a_w_mstatus, c_a_t_jump};
            end else if (mret_i) begin
                act_q = '{c_a_r_mstatus, c_a_r_jump};
            end else if (global_int_en_i && int_flag_i != 2'b00) begin
                m_cause = int_flag_i[1] ? 32'h8000_000B : 32'h8000_0007;
                m_epc   = jump_flag_i ? jump_addr_i : inst_addr_i;
                act_q   = '{c_a_w_mepc, c_a_w_mcause, c_a_w_mstatus, c_a_t_jump};
            end
        end else if (!(is_write(act_q[0]) && ex_csr_we_i)) begin
            void'(act_q.pop_front());
        end
    endtask

    // Inputs are applied at posedge+1; outputs are checked at the negedge.
    task automatic cycle();
        @(negedge clk);
        check_model();
        advance_model();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        ecall_i = 0; ebreak_i = 0; mret_i = 0;
        jump_flag_i = 0; int_flag_i = 2'b00; global_int_en_i = 0; ex_csr_we_i = 0;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int n342;
        int jump_at;
        int ms_writes;

        rst_n = 0;
        idle_inputs();
        inst_addr_i = 0; jump_addr_i = 0;
        csr_mtvec_i = 0; csr_mepc_i = 0; csr_mstatus_i = 0;

        // Reset state, including an event that must not raise hold
        repeat (3) @(posedge clk);
        #1;
        ecall_i = 1;
        #1;
        chk("rst_hold",  32'(hold_flag_o), 0);
        chk("rst_we",    32'(csr_we_o),    0);
        chk("rst_iaddr", int_addr_o,       0);
        ecall_i = 0;
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;

        // ecall: full trap sequence with literal expectations
        inst_addr_i = 32'h100; csr_mtvec_i = 32'h200; csr_mstatus_i = 32'h8;
        ecall_i = 1;
        #1 chk("ec_hold0", 32'(hold_flag_o), 1);
        cycle();
        ecall_i = 0;
        #1 chk("ec_mepc_a", 32'(csr_waddr_o), 32'h341);
        chk("ec_mepc_d", csr_wdata_o, 32'h100);
        cycle();
        #1 chk("ec_mcause_a", 32'(csr_waddr_o), 32'h342);
        chk("ec_mcause_d", csr_wdata_o, 32'd11);
        cycle();
        #1 chk("ec_mstatus_a", 32'(csr_waddr_o), 32'h300);
        chk("ec_mstatus_d", csr_wdata_o, 32'h80);
        cycle();
        #1 chk("ec_assert", 32'(int_assert_o), 1);
        chk("ec_target", int_addr_o, 32'h200);
        chk("ec_hold4", 32'(hold_flag_o), 1);
        cycle();
        #1 chk("ec_hold_end", 32'(hold_flag_o), 0);
        cycle();

        // Timer interrupt while a jump is taken in ex
        idle_inputs();
        global_int_en_i = 1; int_flag_i = 2'b01; jump_flag_i = 1;
        jump_addr_i = 32'h340; inst_addr_i = 32'h500;
        cycle();
        idle_inputs();
        #1 chk("tm_mepc", csr_wdata_o, 32'h340);
        cycle();
        #1 chk("tm_mcause", csr_wdata_o, 32'h8000_0007);
        repeat (3) cycle();

        // Timer + external together
        global_int_en_i = 1; int_flag_i = 2'b11; inst_addr_i = 32'h600;
        cycle();
        idle_inputs();
        cycle();
        #1 chk("ext_mcause", csr_wdata_o, 32'h8000_000B);
        repeat (3) cycle();

        // mret
        csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104;
        mret_i = 1;
        cycle();
        mret_i = 0;
        #1 chk("mret_ms_a", 32'(csr_waddr_o), 32'h300);
        chk("mret_ms_d", csr_wdata_o, 32'h88);
        cycle();
        #1 chk("mret_assert", 32'(int_assert_o), 1);
        chk("mret_target", int_addr_o, 32'h104);
        cycle();
        #1 chk("mret_hold_end", 32'(hold_flag_o), 0);
        cycle();

        // ex write collision during mcause write (two cycles)
        csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h200; inst_addr_i = 32'h700;
        ecall_i = 1;
        cycle();
        ecall_i = 0;
        n342 = 0; jump_at = -1;
        for (int k = 0; k < 8; k++) begin
            ex_csr_we_i = (k == 1 || k == 2);
            #1;
            if (csr_we_o && csr_waddr_o == 12'h342) n342++;
            if (int_assert_o && jump_at < 0) jump_at = k;
            cycle();
        end
        ex_csr_we_i = 0;
        chk("col_mcause_cnt", 32'(n342), 3);
        chk("col_jump_cycle", 32'(jump_at), 5);

        // Reset during the mcause write
        inst_addr_i = 32'h800;
        ecall_i = 1;
        cycle();
        ecall_i = 0;
        cycle();
        #1 chk("rm_in_mcause", 32'(csr_waddr_o), 32'h342);
        rst_n = 0;
        #1;
        chk("rm_we",    32'(csr_we_o),    0);
        chk("rm_waddr", 32'(csr_waddr_o), 0);
        chk("rm_wdata", csr_wdata_o,      0);
        chk("rm_hold",  32'(hold_flag_o), 0);
        act_q.delete();
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        ms_writes = 0;
        for (int k = 0; k < 4; k++) begin
            #1;
            if (csr_we_o) ms_writes++;
            cycle();
        end
        chk("rm_no_writes", 32'(ms_writes), 0);

        // Interrupt with MIE=0 is ignored
        global_int_en_i = 0; int_flag_i = 2'b11;
        for (int k = 0; k < 3; k++) begin
            #1 chk("mie0_hold", 32'(hold_flag_o), 0);
            cycle();
        end
        idle_inputs();

        // Vectored mtvec: external interrupt, then ecall
        csr_mtvec_i = 32'h201;
        global_int_en_i = 1; int_flag_i = 2'b10;
        cycle();
        idle_inputs();
        repeat (3) cycle();
`ifdef CSR_TRAP_VECTORED_EN
        #1 chk("vec_ext_target", int_addr_o, 32'h22C);
`else
        #1 chk("vec_ext_target", int_addr_o, 32'h200);
`endif
        cycle();
        ecall_i = 1;
        cycle();
        ecall_i = 0;
        repeat (3) cycle();
        #1 chk("vec_ecall_target", int_addr_o, 32'h200);
        cycle();

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            ecall_i         = ($urandom_range(0, 15) == 0);
            ebreak_i        = ($urandom_range(0, 15) == 0);
            mret_i          = ($urandom_range(0, 15) == 0);
            int_flag_i      = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00;
            global_int_en_i = 1'($urandom);
            jump_flag_i     = 1'($urandom);
            ex_csr_we_i     = ($urandom_range(0, 3) == 0);
            inst_addr_i     = $urandom;
            jump_addr_i     = $urandom;
            csr_mtvec_i     = $urandom;
            csr_mepc_i      = $urandom;
            csr_mstatus_i   = $urandom;
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
